// File: rtl/dstack_pkg.sv
// Shared instruction package: stack motion encodings, stack depth and instruction format.
package dstack_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        MOV_HOLD = 2'b00,
        MOV_PUSH = 2'b01,
        MOV_POP1 = 2'b10,
        MOV_POP2 = 2'b11
    } movement_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LIT  = 4'h1,
        OP_DUP  = 4'h2,
        OP_DROP = 4'h3,
        OP_SWAP = 4'h4,
        OP_ROT  = 4'h5,
        OP_COPY = 4'h6,
        OP_ADD  = 4'h7,
        OP_SUB  = 4'h8
    } opcode_e;

    typedef struct packed {
        opcode_e             op;
        logic [ADDR_W-1:0]   arg;
    } instr_t;

endpackage

// File: rtl/dstack.sv
// Register-file data stack: push/pop1/pop2/rotate with sticky overflow/underflow flags.
// Single cycle update; top/second/third registered, rotate_value combinational.
module dstack #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = dstack_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [4:0]            rotate_addr,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [5:0]            count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);
    import dstack_pkg::*;

    logic [WORD_WIDTH-1:0] r_entry [DEPTH];
    logic [WORD_WIDTH-1:0] w_next  [DEPTH];
    logic [5:0]            r_count;
    logic                  r_ovf;
    logic                  r_unf;
    logic [5:0]            w_count_next;
    logic                  w_ovf;
    logic                  w_unf;
    logic                  w_rot_en;
    movement_e             w_mov;

    assign w_mov    = movement_e'(movement);
    assign w_rot_en = rotate && (w_mov == MOV_HOLD);

    assign rotate_value = r_entry[rotate_addr];

    // Rotate with address 0 selects entry0 into itself, so it needs no special case.
    assign w_next[0] = w_rot_en ? rotate_value : next_top;

    for (genvar g = 1; g < DEPTH; g++) begin : g_entry
        localparam logic [4:0] IDX = 5'(g);
        logic [WORD_WIDTH-1:0] w_up1;
        logic [WORD_WIDTH-1:0] w_up2;

        if (g + 1 < DEPTH) begin : g_up1
            assign w_up1 = r_entry[g+1];
        end else begin : g_up1_zero
            assign w_up1 = '0;
        end

        if (g + 2 < DEPTH) begin : g_up2
            assign w_up2 = r_entry[g+2];
        end else begin : g_up2_zero
            assign w_up2 = '0;
        end

        assign w_next[g] = w_rot_en               ? ((IDX <= rotate_addr) ? r_entry[g-1] : r_entry[g]) :
                           (w_mov == MOV_PUSH)    ? r_entry[g-1] :
                           (w_mov == MOV_POP1)    ? w_up1 :
                           (w_mov == MOV_POP2)    ? w_up2 :
                                                    r_entry[g];
    end

    always_comb begin
        w_count_next = r_count;
        w_ovf        = 1'b0;
        w_unf        = 1'b0;
        case (w_mov)
            MOV_PUSH: begin
                if (full) w_ovf = 1'b1;
                else      w_count_next = r_count + 6'd1;
            end
            MOV_POP1: begin
                if (r_count < 6'd1) w_unf = 1'b1;
                else                w_count_next = r_count - 6'd1;
            end
            MOV_POP2: begin
                if (r_count < 6'd2) begin
                    w_unf        = 1'b1;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count - 6'd2;
                end
            end
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_entry <= '{default: '0};
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (flush) begin
            r_entry <= '{default: '0};
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_entry <= w_next;
            r_count <= w_count_next;
            if (w_ovf) r_ovf <= 1'b1;
            if (w_unf) r_unf <= 1'b1;
        end
    end

    assign top       = r_entry[0];
    assign second    = r_entry[1];
    assign third     = r_entry[2];
    assign count     = r_count;
    assign empty     = (r_count == 6'd0);
    assign full      = (r_count == 6'(DEPTH));
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_dstack.sv
// Directed, table-driven bench for dstack plus hand-written overflow and async reset sequences.
module tb_dstack;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  movement;
    logic [31:0] next_top;
    logic        rotate;
    logic [4:0]  rotate_addr;
    logic [31:0] top, second, third, rotate_value;
    logic [5:0]  count;
    logic        empty, full, overflow, underflow;

    int n_vec = 0;
    int n_err = 0;

    dstack dut (
        .clk(clk), .reset(reset), .flush(flush), .movement(movement),
        .next_top(next_top), .rotate(rotate), .rotate_addr(rotate_addr),
        .top(top), .second(second), .third(third), .rotate_value(rotate_value),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [1:0]  mov;
        logic [31:0] nt;
        logic        rot;
        logic [4:0]  ra;
        logic        chk_rv;
        logic [31:0] rv;
        logic [31:0] t, s, th;
        logic [5:0]  c;
        logic        ov, un;
    } vec_t;

    localparam logic [31:0] VA = 32'hAAAA_0001;
    localparam logic [31:0] VB = 32'hBBBB_0002;
    localparam logic [31:0] VC = 32'hCCCC_0003;
    localparam logic [31:0] VD = 32'hDDDD_0004;

    vec_t vt [22];

    function automatic vec_t mk(input logic fl, input logic [1:0] mov, input logic [31:0] nt,
                                input logic rot, input logic [4:0] ra, input logic chk_rv,
                                input logic [31:0] rv, input logic [31:0] t, input logic [31:0] s,
                                input logic [31:0] th, input logic [5:0] c, input logic ov,
                                input logic un);
        vec_t v;
        v.fl = fl; v.mov = mov; v.nt = nt; v.rot = rot; v.ra = ra; v.chk_rv = chk_rv; v.rv = rv;
        v.t = t; v.s = s; v.th = th; v.c = c; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input int idx, input logic [31:0] t, input logic [31:0] s,
                             input logic [31:0] th, input logic [5:0] c, input logic ov,
                             input logic un);
        chk($sformatf("v%0d top", idx), 64'(top), 64'(t));
        chk($sformatf("v%0d second", idx), 64'(second), 64'(s));
        chk($sformatf("v%0d third", idx), 64'(third), 64'(th));
        chk($sformatf("v%0d count", idx), 64'(count), 64'(c));
        chk($sformatf("v%0d empty", idx), 64'(empty), 64'(c == 6'd0));
        chk($sformatf("v%0d full", idx), 64'(full), 64'(c == 6'd32));
        chk($sformatf("v%0d overflow", idx), 64'(overflow), 64'(ov));
        chk($sformatf("v%0d underflow", idx), 64'(underflow), 64'(un));
    endtask

    task automatic drive(input logic fl, input logic [1:0] mov, input logic [31:0] nt,
                         input logic rot, input logic [4:0] ra);
        flush = fl; movement = mov; next_top = nt; rotate = rot; rotate_addr = ra;
    endtask

    initial begin
        // flush mov nt rot ra chk_rv rv | top second third count ovf unf
        vt[0]  = mk(0, 2'b01, 32'd1,  0, 0, 0, 0,   32'd1, 32'd0, 32'd0, 6'd1, 0, 0);
        vt[1]  = mk(0, 2'b01, 32'd2,  0, 0, 0, 0,   32'd2, 32'd1, 32'd0, 6'd2, 0, 0);
        vt[2]  = mk(0, 2'b01, 32'd3,  0, 0, 0, 0,   32'd3, 32'd2, 32'd1, 6'd3, 0, 0);
        vt[3]  = mk(0, 2'b10, 32'd5,  0, 0, 0, 0,   32'd5, 32'd1, 32'd0, 6'd2, 0, 0);
        vt[4]  = mk(0, 2'b11, 32'd9,  0, 0, 0, 0,   32'd9, 32'd0, 32'd0, 6'd0, 0, 0);
        vt[5]  = mk(0, 2'b00, 32'd7,  0, 0, 0, 0,   32'd7, 32'd0, 32'd0, 6'd0, 0, 0);
        vt[6]  = mk(0, 2'b10, 32'd0,  0, 0, 0, 0,   32'd0, 32'd0, 32'd0, 6'd0, 0, 1);
        vt[7]  = mk(1, 2'b00, 32'd8,  0, 0, 0, 0,   32'd0, 32'd0, 32'd0, 6'd0, 0, 0);
        vt[8]  = mk(0, 2'b00, VD,     0, 0, 0, 0,   VD,    32'd0, 32'd0, 6'd0, 0, 0);
        vt[9]  = mk(0, 2'b01, VC,     0, 0, 0, 0,   VC,    VD,    32'd0, 6'd1, 0, 0);
        vt[10] = mk(0, 2'b01, VB,     0, 0, 0, 0,   VB,    VC,    VD,    6'd2, 0, 0);
        vt[11] = mk(0, 2'b01, VA,     0, 0, 0, 0,   VA,    VB,    VC,    6'd3, 0, 0);
        vt[12] = mk(0, 2'b00, 32'h55, 1, 3, 1, VD,  VD,    VA,    VB,    6'd3, 0, 0);
        vt[13] = mk(0, 2'b00, 32'h55, 1, 0, 1, VD,  VD,    VA,    VB,    6'd3, 0, 0);
        vt[14] = mk(0, 2'b00, VD,     0, 3, 1, VC,  VD,    VA,    VB,    6'd3, 0, 0);
        vt[15] = mk(0, 2'b01, 32'h77, 1, 2, 1, VB,  32'h77, VD,   VA,    6'd4, 0, 0);
        vt[16] = mk(0, 2'b11, 32'd1,  0, 0, 0, 0,   32'd1, VB,    VC,    6'd2, 0, 0);
        vt[17] = mk(0, 2'b11, 32'd2,  0, 0, 0, 0,   32'd2, 32'd0, 32'd0, 6'd0, 0, 0);
        vt[18] = mk(0, 2'b11, 32'd3,  0, 0, 0, 0,   32'd3, 32'd0, 32'd0, 6'd0, 0, 1);
        vt[19] = mk(1, 2'b01, 32'h99, 0, 0, 0, 0,   32'd0, 32'd0, 32'd0, 6'd0, 0, 0);
        vt[20] = mk(0, 2'b01, 32'd4,  0, 0, 0, 0,   32'd4, 32'd0, 32'd0, 6'd1, 0, 0);
        vt[21] = mk(0, 2'b11, 32'd6,  0, 0, 0, 0,   32'd6, 32'd0, 32'd0, 6'd0, 0, 1);

        reset = 1'b0;
        drive(0, 2'b00, 32'd0, 0, 5'd0);
        #12;
        chk_state(-1, 32'd0, 32'd0, 32'd0, 6'd0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].fl, vt[i].mov, vt[i].nt, vt[i].rot, vt[i].ra);
            #1;
            if (vt[i].chk_rv) chk($sformatf("v%0d rotate_value", i), 64'(rotate_value), 64'(vt[i].rv));
            @(posedge clk);
            #1;
            chk_state(i, vt[i].t, vt[i].s, vt[i].th, vt[i].c, vt[i].ov, vt[i].un);
            @(negedge clk);
        end

        // Fill past capacity: values 0..32 pushed after a flush.
        drive(1, 2'b00, 32'd0, 0, 5'd0);
        @(negedge clk);
        for (int v = 0; v < 33; v++) begin
            drive(0, 2'b01, 32'(v), 0, 5'd31);
            @(negedge clk);
            if (v == 31) begin
                chk("fill32 count", 64'(count), 64'd32);
                chk("fill32 full", 64'(full), 64'd1);
                chk("fill32 overflow", 64'(overflow), 64'd0);
            end
        end
        drive(0, 2'b00, 32'd32, 0, 5'd31);
        #1;
        chk("ovf count", 64'(count), 64'd32);
        chk("ovf full", 64'(full), 64'd1);
        chk("ovf overflow", 64'(overflow), 64'd1);
        chk("ovf top", 64'(top), 64'd32);
        chk("ovf entry31", 64'(rotate_value), 64'd1);
        rotate_addr = 5'd30;
        #1;
        chk("ovf entry30", 64'(rotate_value), 64'd2);

        // Asynchronous reset between edges, then first update on first edge after release.
        @(negedge clk);
        drive(0, 2'b01, 32'h1234, 0, 5'd0);
        #2;
        reset = 1'b0;
        #1;
        chk_state(100, 32'd0, 32'd0, 32'd0, 6'd0, 0, 0);
        @(posedge clk);
        #1;
        chk_state(101, 32'd0, 32'd0, 32'd0, 6'd0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 2'b01, 32'h42, 0, 5'd0);
        @(posedge clk);
        #1;
        chk_state(102, 32'h42, 32'd0, 32'd0, 6'd1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
